// File: rtl/decode_execute_reg.sv
// Decode/Execute pipeline register with stall hold, flush bubble insertion
// and a saturating count of inserted bubbles.
module decode_execute_reg #(
    parameter int XLEN      = 32,
    parameter int RADDR_W   = 5,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic                 RegWriteD,
    input  logic [1:0]           ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [XLEN-1:0]      ImmExtD,
    input  logic [XLEN-1:0]      PCD,
    input  logic [XLEN-1:0]      PCPlus4D,
    input  logic [RADDR_W-1:0]   Rs1D,
    input  logic [RADDR_W-1:0]   Rs2D,
    input  logic [RADDR_W-1:0]   RdD,
    output logic                 ValidE,
    output logic                 RegWriteE,
    output logic [1:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [XLEN-1:0]      ImmExtE,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [RADDR_W-1:0]   Rs1E,
    output logic [RADDR_W-1:0]   Rs2E,
    output logic [RADDR_W-1:0]   RdE,
    output logic [15:0]          BubbleCount
);

    localparam int BW = 8 + ALUCTRL_W + 5 * XLEN + 3 * RADDR_W;

    logic [BW-1:0] bundle_in;
    logic [BW-1:0] bundle_d;
    logic [BW-1:0] bundle_q;
    logic [15:0]   bubble_cnt_d;
    logic [15:0]   bubble_cnt_q;

    assign bundle_in = {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
                        ALUSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
                        Rs1D, Rs2D, RdD};

    // An all-zero bundle is a canonical no-op: add, rd=x0, never a forwarding match.
    always_comb begin
        bundle_d     = bundle_q;
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE) begin
            bundle_d = '0;
            if (bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end else if (!StallE) begin
            bundle_d = bundle_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q     <= '0;
            bubble_cnt_q <= '0;
        end else begin
            bundle_q     <= bundle_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
            ALUSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
            Rs1E, Rs2E, RdE} = bundle_q;

    assign BubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomized and directed bench for decode_execute_reg against a
// behavioural model of the E-stage contents and the bubble counter.
module tb_decode_execute_reg;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    StallE = 1'b0;
    logic    FlushE = 1'b0;
    bundle_t d = '0;

    logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [15:0] BubbleCount;

    bundle_t m = '0;
    int      m_cnt = 0;
    int      n_vec = 0;
    int      n_err = 0;

    always #5 clk = ~clk;

    decode_execute_reg dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .ValidD(d.valid), .RegWriteD(d.regwrite), .ResultSrcD(d.resultsrc),
        .MemWriteD(d.memwrite), .JumpD(d.jump), .BranchD(d.branch),
        .ALUSrcD(d.alusrc), .ALUControlD(d.aluctrl), .RD1D(d.rd1), .RD2D(d.rd2),
        .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pcp4), .Rs1D(d.rs1),
        .Rs2D(d.rs2), .RdD(d.rd),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .BubbleCount(BubbleCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".valid"},     32'(ValidE),      32'(m.valid));
        chk({pfx, ".regwrite"},  32'(RegWriteE),   32'(m.regwrite));
        chk({pfx, ".resultsrc"}, 32'(ResultSrcE),  32'(m.resultsrc));
        chk({pfx, ".memwrite"},  32'(MemWriteE),   32'(m.memwrite));
        chk({pfx, ".jump"},      32'(JumpE),       32'(m.jump));
        chk({pfx, ".branch"},    32'(BranchE),     32'(m.branch));
        chk({pfx, ".alusrc"},    32'(ALUSrcE),     32'(m.alusrc));
        chk({pfx, ".aluctrl"},   32'(ALUControlE), 32'(m.aluctrl));
        chk({pfx, ".rd1"},       RD1E,             m.rd1);
        chk({pfx, ".rd2"},       RD2E,             m.rd2);
        chk({pfx, ".imm"},       ImmExtE,          m.imm);
        chk({pfx, ".pc"},        PCE,              m.pc);
        chk({pfx, ".pcp4"},      PCPlus4E,         m.pcp4);
        chk({pfx, ".rs1"},       32'(Rs1E),        32'(m.rs1));
        chk({pfx, ".rs2"},       32'(Rs2E),        32'(m.rs2));
        chk({pfx, ".rd"},        32'(RdE),         32'(m.rd));
        chk({pfx, ".bubbles"},   32'(BubbleCount), 32'(m_cnt));
    endtask

    // One clock edge: the model applies flush > stall > load, then outputs are checked.
    task automatic tick(input string pfx, input bit do_chk);
        @(posedge clk);
        if (FlushE) begin
            m = '0;
            m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end else if (!StallE) begin
            m = d;
        end
        #1;
        if (do_chk) check_all(pfx);
    endtask

    task automatic rand_d();
        d.valid     = 1'($urandom);
        d.regwrite  = 1'($urandom);
        d.resultsrc = 2'($urandom_range(0, 2));
        d.memwrite  = 1'($urandom);
        d.jump      = 1'($urandom);
        d.branch    = 1'($urandom);
        d.alusrc    = 1'($urandom);
        d.aluctrl   = 3'($urandom);
        d.rd1       = $urandom;
        d.rd2       = $urandom;
        d.imm       = $urandom;
        d.pc        = $urandom & 32'hFFFF_FFFC;
        d.pcp4      = d.pc + 32'd4;
        d.rs1       = 5'($urandom);
        d.rs2       = 5'($urandom);
        d.rd        = 5'($urandom);
    endtask

    initial begin
        // reset held across several edges
        rand_d();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // plain load, and nothing visible before the edge
        d = '0;
        d.valid = 1'b1; d.regwrite = 1'b1; d.aluctrl = 3'b001;
        d.rd1 = 32'h10; d.rd2 = 32'h3; d.rd = 5'd5;
        #1;
        check_all("load_pre");
        tick("load", 1'b1);

        // stall holds for three edges, then picks up the new values
        d.aluctrl = 3'b010; d.pc = 32'h40;
        tick("stall_ld", 1'b1);
        StallE = 1'b1;
        d.aluctrl = 3'b011; d.pc = 32'h44;
        for (int i = 0; i < 3; i++) begin
            tick("stall_hold", 1'b1);
            chk("stall_pc", PCE, 32'h40);
        end
        StallE = 1'b0;
        tick("stall_rel", 1'b1);
        chk("stall_rel_alu", 32'(ALUControlE), 32'h3);

        // flush beats stall
        rand_d();
        d.memwrite = 1'b1; d.rd = 5'd7; d.valid = 1'b1;
        StallE = 1'b1; FlushE = 1'b1;
        tick("flush_stall", 1'b1);
        chk("flush_cnt1", 32'(BubbleCount), 32'd1);
        StallE = 1'b0; FlushE = 1'b0;

        // random mix
        for (int i = 0; i < 300; i++) begin
            rand_d();
            FlushE = ($urandom_range(0, 7) == 0);
            StallE = ($urandom_range(0, 3) == 0);
            tick("rand", 1'b1);
        end
        FlushE = 1'b0; StallE = 1'b0;

        // async reset in the middle of a cycle
        rst = 1'b1; #1; m = '0; m_cnt = 0;
        @(negedge clk); rst = 1'b0;
        FlushE = 1'b1;
        repeat (4) tick("pre_rst_flush", 1'b0);
        FlushE = 1'b0;
        rand_d(); d.valid = 1'b1; d.rd = 5'd9;
        tick("pre_rst", 1'b1);
        chk("pre_rst_cnt", 32'(BubbleCount), 32'd4);
        rand_d();
        StallE = 1'b1;
        #2; rst = 1'b1; #1;
        m = '0; m_cnt = 0;
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_hold");
        @(negedge clk); rst = 1'b0;
        StallE = 1'b0;
        rand_d();
        tick("post_rst", 1'b1);

        // saturation of the bubble counter
        FlushE = 1'b1;
        repeat (65534) tick("sat_fill", 1'b0);
        #1;
        chk("sat_fffe", 32'(BubbleCount), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            rand_d();
            tick("sat", 1'b1);
            chk("sat_ffff", 32'(BubbleCount), 32'hFFFF);
        end
        FlushE = 1'b0;
        tick("after_sat", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Pipeline register between Decode and Execute in the 5-stage RV32I core.
- Captures the decoded control bundle (including the 3-bit ALU operation code), register-file read data, immediate, PC values and register addresses at the end of Decode and presents them to Execute one cycle later.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Carries a valid bit so downstream logic and the retire counter can tell real instructions from bubbles.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- RADDR_W, 5, register-file address width.
- ALUCTRL_W, 3, width of the ALU operation code.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- StallE  input  1  hold all E-stage contents.
- FlushE  input  1  replace the next E-stage contents with a bubble.
- ValidD  input  1  Decode holds a real instruction.
- RegWriteD  input  1  destination register write enable.
- ResultSrcD  input  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
- MemWriteD  input  1  store enable.
- JumpD  input  1  JAL.
- BranchD  input  1  conditional branch.
- ALUSrcD  input  1  operand B select: 1 = immediate.
- ALUControlD  input  ALUCTRL_W  ALU operation code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1D  input  XLEN  rs1 read data.
- RD2D  input  XLEN  rs2 read data.
- ImmExtD  input  XLEN  sign-extended immediate.
- PCD  input  XLEN  instruction PC.
- PCPlus4D  input  XLEN  PC+4.
- Rs1D  input  RADDR_W  rs1 address, for forwarding.
- Rs2D  input  RADDR_W  rs2 address, for forwarding.
- RdD  input  RADDR_W  rd address.
- Outputs: one E-suffixed output of identical width for each D-suffixed input above (ValidE, RegWriteE … RdE).
- BubbleCount  output  16  number of bubbles inserted by FlushE since reset.

Behaviour:
- Reset (rst=1, asynchronous, any time):
  - All outputs go to 0 immediately, including BubbleCount.
  - ValidE=0 and ALUControlE=000.
  - Holds while rst is high. First capture occurs at the first rising edge after deassertion.
- Per-edge priority: rst > FlushE > StallE > load.
- Load (FlushE=0, StallE=0):
  - Every E output takes its D input.
  - Latency exactly 1 cycle. No combinational path from any D input to any E output.
- Stall (StallE=1, FlushE=0): all E outputs and BubbleCount hold their values.
- Flush (FlushE=1, regardless of StallE):
  - ValidE, RegWriteE, MemWriteE, JumpE and BranchE all become 0.
  - ResultSrcE, ALUSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E and RdE all become 0.
  - All-zero makes the bubble a canonical no-op: add, rd=x0, no forwarding match.
- BubbleCount:
  - Increments by 1 on every edge where FlushE=1 and rst=0.
  - Saturates at 16'hFFFF; no wrap.
  - Unaffected by StallE.
- ValidD=0 with FlushE=0: loaded as-is. ValidE follows ValidD; control bits are passed unmodified. Decode is responsible for zeroing control on invalid slots.
- FlushE and StallE both high: flush wins. The bubble is loaded and BubbleCount increments.
- Consecutive flushes: each cycle inserts a bubble and increments the counter.
- Reset mid-stall or mid-flush: reset wins. After release the register behaves as freshly reset (counter=0).
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset, then load with FlushE=StallE=0, RegWriteD=1, ALUControlD=001, RD1D=32'h0000_0010, RD2D=32'h0000_0003, RdD=5, ValidD=1 -> next cycle RegWriteE=1, ALUControlE=001, RD1E=0x10, RD2E=0x3, RdE=5, ValidE=1. Nothing changes before the edge.
- Load ALUControlD=010, PCD=32'h0000_0040; assert StallE for 3 cycles while D inputs change to ALUControlD=011, PCD=0x44 -> E holds 010 / 0x40 for all 3 cycles. Takes 011 / 0x44 one edge after StallE drops.
- FlushE=1 with StallE=1 and MemWriteD=1, RdD=7 -> next cycle all E outputs 0 (MemWriteE=0, RdE=0, ValidE=0). BubbleCount goes 0->1.
- Force BubbleCount to 16'hFFFE via 65534 flush cycles, then 3 more flushes -> reads 16'hFFFF and stays there.
- With ValidE=1, RdE=9, BubbleCount=4, assert rst asynchronously mid-cycle -> all outputs 0 before the next clock edge. After release plus one load edge, E reflects the D inputs and BubbleCount=0.
